hamming_weight_acc: RTL and testbench

//  Sequential, parametrised Hamming-weight engine for the ISO7816-3 test/checker path.

---
 rtl/hamming_weight_acc_pkg.sv | 42 ++++
 rtl/hamming_weight_acc_popcount.sv | 18 +
 rtl/hamming_weight_acc.sv | 162 ++++++++++++++++
 tb/tb_hamming_weight_acc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_weight_acc_pkg.sv
// Shared definitions for the Hamming-weight engine: FSM encodings and
// constant helper functions used to size the datapath and vet parameters.
package hamming_weight_acc_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int result;
        int remain;
        result = 0;
        remain = value - 1;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

    // Chunk index register width; kept at least one bit so NCHUNK=1 still builds.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? clog2(nchunk) : 1;
    endfunction

    // Word must split evenly into chunks, and the weight/total registers
    // must be able to hold a full-word count.
    function automatic bit params_legal(input int data_width,
                                        input int chunk_width,
                                        input int weight_width,
                                        input int acc_width);
        bit ok;
        ok = 1'b1;
        if (chunk_width < 1 || data_width < chunk_width)  ok = 1'b0;
        if (chunk_width > 0 && (data_width % chunk_width) != 0) ok = 1'b0;
        if (weight_width < clog2(data_width + 1))          ok = 1'b0;
        if (acc_width < weight_width)                      ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/hamming_weight_acc_popcount.sv
// Combinational population count of a small word; used on one chunk per cycle.
module hamming_weight_acc_popcount #(
    parameter int DATA_WIDTH   = 4,
    parameter int WEIGHT_WIDTH = 3
) (
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [WEIGHT_WIDTH-1:0] weight_o
);

    // Ripple sum of the individual bits.
    always_comb begin
        weight_o = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            weight_o = weight_o + WEIGHT_WIDTH'(data_i[i]);
        end
    end

endmodule

// File: rtl/hamming_weight_acc.sv
// Sequential Hamming-weight engine: counts a word CHUNK_WIDTH bits per cycle
// behind valid/ready handshakes, reports parity, and keeps a saturating
// running total of weights for words flagged with accumulate.
module hamming_weight_acc
    import hamming_weight_acc_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CHUNK_WIDTH  = 4,
    parameter int WEIGHT_WIDTH = 4,
    parameter int ACC_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    inValid,
    output logic                    inReady,
    input  logic [DATA_WIDTH-1:0]   dataIn,
    input  logic                    accumulate,
    output logic                    outValid,
    input  logic                    outReady,
    output logic [WEIGHT_WIDTH-1:0] hammingWeight,
    output logic                    parity,
    input  logic                    clear,
    output logic [ACC_WIDTH-1:0]    accWeight,
    output logic                    accOverflow
);

    localparam int NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam int CW_W   = clog2(CHUNK_WIDTH + 1);

    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NCHUNK - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX  = '1;

    if (!params_legal(DATA_WIDTH, CHUNK_WIDTH, WEIGHT_WIDTH, ACC_WIDTH)) begin : g_param_check
        $error("hamming_weight_acc: illegal DATA/CHUNK/WEIGHT/ACC width combination");
    end

    logic [1:0]              state_q,      state_d;
    logic [DATA_WIDTH-1:0]   data_q,       data_d;
    logic                    acc_en_q,     acc_en_d;
    logic [IDX_W-1:0]        idx_q,        idx_d;
    logic [WEIGHT_WIDTH-1:0] partial_q,    partial_d;
    logic [WEIGHT_WIDTH-1:0] weight_q,     weight_d;
    logic [ACC_WIDTH-1:0]    acc_weight_q, acc_weight_d;
    logic                    acc_ovf_q,    acc_ovf_d;

    logic [CHUNK_WIDTH-1:0]  chunk;
    logic [CW_W-1:0]         chunk_weight;
    logic [WEIGHT_WIDTH-1:0] partial_sum;
    logic [ACC_WIDTH:0]      acc_sum;
    logic                    out_hs;

    // Pick the chunk addressed by the index; chunk 0 holds the LSBs.
    always_comb begin
        chunk = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (idx_q == IDX_W'(c)) begin
                chunk = data_q[c*CHUNK_WIDTH +: CHUNK_WIDTH];
            end
        end
    end

    hamming_weight_acc_popcount #(
        .DATA_WIDTH   (CHUNK_WIDTH),
        .WEIGHT_WIDTH (CW_W)
    ) u_chunk_count (
        .data_i   (chunk),
        .weight_o (chunk_weight)
    );

    assign partial_sum = partial_q + WEIGHT_WIDTH'(chunk_weight);
    assign out_hs      = (state_q == ST_DONE) && outReady;

    // FSM and counting datapath; the result register only updates on the
    // final chunk so the outputs hold between words.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        acc_en_d  = acc_en_q;
        idx_d     = idx_q;
        partial_d = partial_q;
        weight_d  = weight_q;
        case (state_q)
            ST_IDLE: begin
                if (inValid) begin
                    data_d    = dataIn;
                    acc_en_d  = accumulate;
                    idx_d     = '0;
                    partial_d = '0;
                    state_d   = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (idx_q == LAST_IDX) begin
                    weight_d = partial_sum;
                    state_d  = ST_DONE;
                end else begin
                    partial_d = partial_sum;
                    idx_d     = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (outReady) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating running total; clear takes priority over a same-edge add,
    // and a sum that would exceed the maximum pins it and flags overflow.
    always_comb begin
        acc_sum      = {1'b0, acc_weight_q} + (ACC_WIDTH+1)'(weight_q);
        acc_weight_d = acc_weight_q;
        acc_ovf_d    = acc_ovf_q;
        if (clear) begin
            acc_weight_d = '0;
            acc_ovf_d    = 1'b0;
        end else if (out_hs && acc_en_q) begin
            if (acc_sum[ACC_WIDTH]) begin
                acc_weight_d = ACC_MAX;
                acc_ovf_d    = 1'b1;
            end else begin
                acc_weight_d = acc_sum[ACC_WIDTH-1:0];
            end
        end
    end

    // State registers; reset aborts any in-flight word.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q      <= ST_IDLE;
            data_q       <= '0;
            acc_en_q     <= 1'b0;
            idx_q        <= '0;
            partial_q    <= '0;
            weight_q     <= '0;
            acc_weight_q <= '0;
            acc_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            acc_en_q     <= acc_en_d;
            idx_q        <= idx_d;
            partial_q    <= partial_d;
            weight_q     <= weight_d;
            acc_weight_q <= acc_weight_d;
            acc_ovf_q    <= acc_ovf_d;
        end
    end

    assign inReady       = (state_q == ST_IDLE);
    assign outValid      = (state_q == ST_DONE);
    assign hammingWeight = weight_q;
    assign parity        = weight_q[0];
    assign accWeight     = acc_weight_q;
    assign accOverflow   = acc_ovf_q;

endmodule

// File: tb/tb_hamming_weight_acc.sv
// Directed bench for hamming_weight_acc (8-bit word, 4-bit chunks, 8-bit total).
module tb_hamming_weight_acc;

    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int WW  = 4;
    localparam int AW  = 8;
    localparam int NCH = DW / CW;

    logic          clk = 1'b0;
    logic          nReset;
    logic          inValid;
    logic          inReady;
    logic [DW-1:0] dataIn;
    logic          accumulate;
    logic          outValid;
    logic          outReady;
    logic [WW-1:0] hammingWeight;
    logic          parity;
    logic          clear;
    logic [AW-1:0] accWeight;
    logic          accOverflow;

    typedef struct {
        logic [WW-1:0] w;
        logic          p;
    } exp_t;

    exp_t sb_q[$];
    int   passes = 0;
    int   fails  = 0;
    int   checks = 0;
    int   model_acc = 0;
    logic model_ovf = 1'b0;

    always #5 clk = ~clk;

    hamming_weight_acc #(
        .DATA_WIDTH   (DW),
        .CHUNK_WIDTH  (CW),
        .WEIGHT_WIDTH (WW),
        .ACC_WIDTH    (AW)
    ) dut (
        .clk           (clk),
        .nReset        (nReset),
        .inValid       (inValid),
        .inReady       (inReady),
        .dataIn        (dataIn),
        .accumulate    (accumulate),
        .outValid      (outValid),
        .outReady      (outReady),
        .hammingWeight (hammingWeight),
        .parity        (parity),
        .clear         (clear),
        .accWeight     (accWeight),
        .accOverflow   (accOverflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word end to end: accept, latency, optional back-pressure, handshake.
    task automatic do_word(input logic [DW-1:0] d, input logic acc,
                           input logic clr, input int hold);
        exp_t e;
        exp_t got;
        int   s;
        chk("in_ready_idle", 32'(inReady), 1);
        dataIn     = d;
        accumulate = acc;
        inValid    = 1'b1;
        tick();
        inValid    = 1'b0;
        accumulate = 1'b0;
        e.w = WW'($countones(d));
        e.p = ^d;
        sb_q.push_back(e);
        chk("in_ready_busy", 32'(inReady), 0);
        for (int i = 0; i < NCH; i++) begin
            chk("latency_low", 32'(outValid), 0);
            tick();
        end
        chk("latency_high", 32'(outValid), 1);
        if (hold > 0) begin
            inValid = 1'b1;
            dataIn  = ~d;
            for (int h = 0; h < hold; h++) begin
                tick();
                chk("hold_valid", 32'(outValid), 1);
                chk("hold_in_ready", 32'(inReady), 0);
                chk("hold_weight", 32'(hammingWeight), 32'(e.w));
            end
            inValid = 1'b0;
        end
        chk("sb_nonempty", 32'(sb_q.size()), 1);
        got = e;
        if (sb_q.size() > 0) got = sb_q.pop_front();
        chk("weight", 32'(hammingWeight), 32'(got.w));
        chk("parity", 32'(parity), 32'(got.p));
        outReady = 1'b1;
        clear    = clr;
        tick();
        outReady = 1'b0;
        clear    = 1'b0;
        if (clr) begin
            model_acc = 0;
            model_ovf = 1'b0;
        end else if (acc) begin
            s = model_acc + int'(got.w);
            if (s > (1 << AW) - 1) begin
                model_acc = (1 << AW) - 1;
                model_ovf = 1'b1;
            end else begin
                model_acc = s;
            end
        end
        chk("idle_in_ready", 32'(inReady), 1);
        chk("idle_out_valid", 32'(outValid), 0);
        chk("weight_held", 32'(hammingWeight), 32'(got.w));
        chk("acc_weight", 32'(accWeight), 32'(model_acc));
        chk("acc_overflow", 32'(accOverflow), 32'(model_ovf));
    endtask

    initial begin
        nReset     = 1'b0;
        inValid    = 1'b0;
        dataIn     = '0;
        accumulate = 1'b0;
        outReady   = 1'b0;
        clear      = 1'b0;

        // Reset state
        #1;
        chk("rst_in_ready", 32'(inReady), 1);
        chk("rst_out_valid", 32'(outValid), 0);
        chk("rst_weight", 32'(hammingWeight), 0);
        chk("rst_parity", 32'(parity), 0);
        chk("rst_acc", 32'(accWeight), 0);
        chk("rst_ovf", 32'(accOverflow), 0);
        tick();
        tick();
        nReset = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(inReady), 1);
        chk("post_rst_out_valid", 32'(outValid), 0);

        // Basic words
        do_word(8'hB5, 1'b0, 1'b0, 0);
        chk("b5_weight_const", 32'(hammingWeight), 5);
        chk("b5_parity_const", 32'(parity), 1);
        do_word(8'h00, 1'b0, 1'b0, 0);
        chk("zero_weight_const", 32'(hammingWeight), 0);
        do_word(8'hFF, 1'b0, 1'b0, 0);
        chk("ff_weight_const", 32'(hammingWeight), 8);
        chk("ff_parity_const", 32'(parity), 0);

        // Back-pressure with inValid held high
        do_word(8'h3C, 1'b0, 1'b0, 5);
        tick();
        chk("no_extra_word", 32'(outValid), 0);
        chk("no_extra_ready", 32'(inReady), 1);

        // Saturation
        for (int n = 1; n <= 32; n++) begin
            do_word(8'hFF, 1'b1, 1'b0, 0);
            if (n == 31) begin
                chk("acc_31_words", 32'(accWeight), 248);
                chk("ovf_31_words", 32'(accOverflow), 0);
            end
        end
        chk("acc_saturated", 32'(accWeight), 255);
        chk("ovf_set", 32'(accOverflow), 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        model_acc = 0;
        model_ovf = 1'b0;
        chk("clear_acc", 32'(accWeight), 0);
        chk("clear_ovf", 32'(accOverflow), 0);

        // Clear racing an accumulating handshake
        for (int n = 0; n < 5; n++) do_word(8'hFF, 1'b1, 1'b0, 0);
        chk("acc_40", 32'(accWeight), 40);
        do_word(8'hFF, 1'b1, 1'b1, 0);
        chk("clear_wins", 32'(accWeight), 0);
        do_word(8'h0F, 1'b1, 1'b0, 0);
        chk("acc_after_clear", 32'(accWeight), 4);

        // Reset mid-COUNT
        dataIn     = 8'hAA;
        accumulate = 1'b1;
        inValid    = 1'b1;
        tick();
        inValid    = 1'b0;
        accumulate = 1'b0;
        chk("abort_in_count", 32'(inReady), 0);
        nReset = 1'b0;
        #1;
        chk("abort_out_valid", 32'(outValid), 0);
        chk("abort_in_ready", 32'(inReady), 1);
        chk("abort_acc", 32'(accWeight), 0);
        tick();
        nReset = 1'b1;
        model_acc = 0;
        model_ovf = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("abort_no_result", 32'(outValid), 0);
        end
        chk("abort_acc_after", 32'(accWeight), 0);
        do_word(8'h81, 1'b1, 1'b0, 0);
        chk("w81_weight_const", 32'(hammingWeight), 2);
        chk("w81_acc_const", 32'(accWeight), 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
